scratch_ram_arbiter: RTL and testbench

Shares the single-port scratch RAM between two requesters (A: CPU datapath, B: secondary master such as an I/O or stack engine) with round-robin arbitration and a req/grant handshake. It also owns RAM initialisation: after every reset, and on demand, it sweeps all locations to zero before granting any access. It sits between the requesters and the scratch RAM's DATA_IN/SCR_ADDR/SCR_WE/DATA_OUT pins. The RAM writes synchronously and reads asynchronously.

---
 rtl/scratch_ram_arbiter_if.sv | 70 +++++++
 rtl/scratch_ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_scratch_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scratch_ram_arbiter_if.sv
// Bundle of requester, control and scratch RAM pins around scratch_ram_arbiter.
//
// Requester A / B (driven by the requesters, sampled by the arbiter):
//   req_x    access request, held until granted
//   we_x     1 = write, 0 = read; valid while req_x is high
//   addr_x   access address
//   wdata_x  write data
// Requester A / B (driven by the arbiter):
//   gnt_x    combinational grant; the access commits at the edge where it is high
//   rdata_x  registered read data, held until the next read by that requester
//   rvalid_x one-cycle pulse marking fresh rdata_x
// Control:
//   clr_start single-cycle pulse requesting a zero sweep
//   busy      high while the RAM is being initialised or cleared
// Scratch RAM pins:
//   scr_addr / scr_din / scr_we  address, write data and write enable to the RAM
//   scr_dout                     asynchronous read data from the RAM
//
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (requesters, controller and the RAM itself).
interface scratch_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 10
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  logic              clr_start;
  logic              busy;

  logic [ADDR_W-1:0] scr_addr;
  logic [DATA_W-1:0] scr_din;
  logic              scr_we;
  logic [DATA_W-1:0] scr_dout;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  clr_start,
    input  scr_dout,
    output gnt_a, rdata_a, rvalid_a,
    output gnt_b, rdata_b, rvalid_b,
    output busy,
    output scr_addr, scr_din, scr_we
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output clr_start,
    output scr_dout,
    input  gnt_a, rdata_a, rvalid_a,
    input  gnt_b, rdata_b, rvalid_b,
    input  busy,
    input  scr_addr, scr_din, scr_we
  );
endinterface

// File: rtl/scratch_ram_arbiter.sv
// scratch_ram_arbiter: shares one single-port scratch RAM between two requesters.
//
// Requester A (CPU datapath) and requester B (secondary master) compete for the
// RAM with round-robin arbitration: on a tie the requester that was not granted
// most recently wins, and a lone requester is granted every cycle it asks.
// The RAM writes on the rising clock edge and reads combinationally, so a read
// grant captures scr_dout into rdata_x at the grant edge and pulses rvalid_x
// for the following cycle.
//
// After every reset, and whenever clr_start is pulsed while running, the block
// sweeps every RAM location to zero before granting anything again. busy is
// high for the whole INIT/CLEAR period.
//
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    scratch_ram_arbiter_if.slave: requester handshakes, clr_start/busy
//          and the scratch RAM pins (see the interface file for the signal list)
module scratch_ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 10
) (
  input logic                  CLK,
  input logic                  RST_N,
  scratch_ram_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] ClrLast = '1;

  typedef enum logic [1:0] {
    StInit,
    StClear,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  // 1 when B held the most recent grant; resetting to B lets A win the first tie.
  logic              last_gnt_b_q, last_gnt_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;

  logic              gnt_a;
  logic              gnt_b;
  logic              busy;
  logic              scr_we;
  logic [ADDR_W-1:0] scr_addr;
  logic [DATA_W-1:0] scr_din;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StInit;
      clr_cnt_q    <= '0;
      last_gnt_b_q <= 1'b1;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_gnt_b_q <= last_gnt_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_gnt_b_d = last_gnt_b_q;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    rvalid_a_d   = 1'b0;
    rvalid_b_d   = 1'b0;

    unique case (state_q)
      StInit: begin
        state_d   = StClear;
        clr_cnt_d = '0;
      end
      StClear: begin
        // clr_start is deliberately ignored here so a sweep is never extended.
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ClrLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A grant issued alongside clr_start still commits at this edge below.
        if (bus.clr_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase

    // Round-robin pointer only moves on cycles that carry a grant.
    if (gnt_a) begin
      last_gnt_b_d = 1'b0;
      if (!bus.we_a) begin
        rdata_a_d  = bus.scr_dout;
        rvalid_a_d = 1'b1;
      end
    end else if (gnt_b) begin
      last_gnt_b_d = 1'b1;
      if (!bus.we_b) begin
        rdata_b_d  = bus.scr_dout;
        rvalid_b_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: arbitration and RAM pin muxing
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    busy     = 1'b1;
    scr_we   = 1'b0;
    scr_addr = '0;
    scr_din  = '0;

    unique case (state_q)
      StInit: begin
        busy = 1'b1;
      end
      StClear: begin
        scr_we   = 1'b1;
        scr_addr = clr_cnt_q;
      end
      StRun: begin
        busy = 1'b0;
        // A wins when alone, or on a tie when B was granted last.
        if (bus.req_a && (!bus.req_b || last_gnt_b_q)) begin
          gnt_a = 1'b1;
        end else if (bus.req_b) begin
          gnt_b = 1'b1;
        end

        if (gnt_a) begin
          scr_we   = bus.we_a;
          scr_addr = bus.addr_a;
          scr_din  = bus.wdata_a;
        end else if (gnt_b) begin
          scr_we   = bus.we_b;
          scr_addr = bus.addr_b;
          scr_din  = bus.wdata_b;
        end
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.busy     = busy;
  assign bus.scr_we   = scr_we;
  assign bus.scr_addr = scr_addr;
  assign bus.scr_din  = scr_din;

  // Grants are exclusive and only ever issued while running.
  a_gnt_exclusive: assert property (@(posedge CLK) disable iff (!RST_N) !(gnt_a && gnt_b));
  a_gnt_in_run: assert property (@(posedge CLK) disable iff (!RST_N)
                                 (gnt_a || gnt_b) |-> (state_q == StRun));

endmodule

// File: tb/tb_scratch_ram_arbiter.sv
module tb_scratch_ram_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  scratch_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  scratch_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // Scratch RAM: synchronous write, asynchronous read, power-up garbage.
  logic [DATA_W-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ram[i] <= DATA_W'($urandom);
    forever begin
      @(posedge CLK);
      if (bus.scr_we === 1'b1) ram[bus.scr_addr] <= bus.scr_din;
    end
  end
  assign bus.scr_dout = ram[bus.scr_addr];

  // Reference model state.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t              q_a[$];
  exp_t              q_b[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] hold_a = '0;
  logic [DATA_W-1:0] hold_b = '0;
  bit                run = 1'b0;
  int                last_winner = 1;  // 0 = A, 1 = B
  int                cyc = 0;
  int                errors = 0;
  int                checks = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: read responses are popped from the scoreboard when due.
  always @(negedge CLK) begin
    exp_t e;
    bit   due;
    if (!RST_N) begin
      hold_a = '0;
      hold_b = '0;
    end else begin
      due = (q_a.size() > 0) && (q_a[0].cyc <= cyc);
      check("rvalid_a", 32'(bus.rvalid_a), 32'(due));
      if (due) begin
        e      = q_a.pop_front();
        hold_a = e.data;
      end
      check("rdata_a", 32'(bus.rdata_a), 32'(hold_a));
      due = (q_b.size() > 0) && (q_b[0].cyc <= cyc);
      check("rvalid_b", 32'(bus.rvalid_b), 32'(due));
      if (due) begin
        e      = q_b.pop_front();
        hold_b = e.data;
      end
      check("rdata_b", 32'(bus.rdata_b), 32'(hold_b));
    end
  end

  task automatic reset_checks();
    check("rst_gnt", 32'({bus.gnt_a, bus.gnt_b}), 32'(0));
    check("rst_rvalid", 32'({bus.rvalid_a, bus.rvalid_b}), 32'(0));
    check("rst_rdata_a", 32'(bus.rdata_a), 32'(0));
    check("rst_rdata_b", 32'(bus.rdata_b), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(1));
    check("rst_scr_bus", 32'({bus.scr_we, bus.scr_addr, bus.scr_din}), 32'(0));
  endtask

  // Called just after a negedge; asserts reset and checks outputs right away.
  task automatic apply_reset();
    RST_N = 1'b0;
    q_a.delete();
    q_b.delete();
    hold_a      = '0;
    hold_b      = '0;
    run         = 1'b0;
    last_winner = 1;
    #1;
    reset_checks();
  endtask

  // One bus cycle: drive, check grant/RAM pins against the model, update model.
  task automatic drive(input logic ra, input logic wa, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] da, input logic rb, input logic wb,
                       input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db,
                       input logic clr, output bit ga, output bit gb);
    logic [ADDR_W+DATA_W:0] exp_bus;
    bus.req_a = ra;  bus.we_a = wa;  bus.addr_a = aa;  bus.wdata_a = da;
    bus.req_b = rb;  bus.we_b = wb;  bus.addr_b = ab;  bus.wdata_b = db;
    bus.clr_start = clr;
    #1;
    // Winner: the sole requester, or on a tie whoever was not granted last.
    ga = run && ra && (!rb || last_winner == 1);
    gb = run && rb && !ga;
    check("gnt", 32'({bus.gnt_a, bus.gnt_b}), 32'({ga, gb}));
    check("busy_run", 32'(bus.busy), 32'(!run));
    exp_bus = '0;
    if (ga) exp_bus = {wa, aa, da};
    if (gb) exp_bus = {wb, ab, db};
    check("scr_bus", 32'({bus.scr_we, bus.scr_addr, bus.scr_din}), 32'(exp_bus));
    if (ga) begin
      if (wa) ref_mem[aa] = da;
      else q_a.push_back('{data: ref_mem[aa], cyc: cyc + 1});
      last_winner = 0;
    end
    if (gb) begin
      if (wb) ref_mem[ab] = db;
      else q_b.push_back('{data: ref_mem[ab], cyc: cyc + 1});
      last_winner = 1;
    end
    if (clr && run) run = 1'b0;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int k = 0; k < n; k++) drive(0, 0, '0, '0, 0, 0, '0, '0, 0, ga, gb);
  endtask

  // Entered at the negedge of the first CLEAR cycle. Optionally pulses clr_start
  // at step clr_at, or drops reset at step rst_at.
  task automatic sweep(input int rst_at, input int clr_at);
    int    bad = 0;
    string first = "";
    bit    aborted = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.req_a     = 1'b1;
      bus.we_a      = 1'($urandom);
      bus.addr_a    = ADDR_W'($urandom);
      bus.wdata_a   = DATA_W'($urandom);
      bus.req_b     = 1'($urandom);
      bus.we_b      = 1'($urandom);
      bus.addr_b    = ADDR_W'($urandom);
      bus.wdata_b   = DATA_W'($urandom);
      bus.clr_start = (i == clr_at);
      #1;
      if (bus.scr_we !== 1'b1 || bus.scr_addr !== ADDR_W'(i) || bus.scr_din !== '0 ||
          bus.busy !== 1'b1 || bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
        if (bad == 0)
          first = $sformatf("step %0d we=%b addr=0x%0h din=0x%0h busy=%b gnt=%b%b",
                            i, bus.scr_we, bus.scr_addr, bus.scr_din, bus.busy,
                            bus.gnt_a, bus.gnt_b);
        bad++;
      end
      if (i == rst_at) begin
        aborted = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    bus.clr_start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep: %0d bad cycles, required 0; first %s", bad, first);
    end
    if (aborted) begin
      apply_reset();
    end else begin
      #1;
      check("busy_after_sweep", 32'(bus.busy), 32'(0));
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
      run = 1'b1;
    end
  endtask

  task automatic release_and_sweep(input int rst_at);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);  // edge 1: INIT -> CLEAR
    sweep(rst_at, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ga, gb;
    logic pa, pwa, pb, pwb;
    logic [ADDR_W-1:0] paa, pab;
    logic [DATA_W-1:0] pda, pdb;

    bus.req_a = 1'b1;  bus.we_a = 1'b0;  bus.addr_a = '0;  bus.wdata_a = '0;
    bus.req_b = 1'b0;  bus.we_b = 1'b0;  bus.addr_b = '0;  bus.wdata_b = '0;
    bus.clr_start = 1'b0;

    // Reset held across several edges with A requesting.
    #2 reset_checks();
    repeat (2) @(negedge CLK);
    #1 reset_checks();
    release_and_sweep(-1);

    // A write then read; A granted in the first RUN cycle.
    drive(1, 1, 8'h10, 10'h2AB, 0, 0, '0, '0, 0, ga, gb);
    drive(1, 0, 8'h10, 10'h000, 0, 0, '0, '0, 0, ga, gb);
    idle(1);

    // Cross-port and never-written location.
    drive(0, 0, '0, '0, 1, 1, 8'hFF, 10'h155, 0, ga, gb);
    drive(1, 0, 8'hFF, '0, 0, 0, '0, '0, 0, ga, gb);
    drive(1, 0, 8'h00, '0, 0, 0, '0, '0, 0, ga, gb);

    // B alone three cycles in a row.
    for (int k = 0; k < 3; k++) drive(0, 0, '0, '0, 1, 0, 8'h10, '0, 0, ga, gb);
    idle(1);

    // Re-clear with an ignored mid-sweep clr_start.
    drive(1, 1, 8'h20, 10'h3FF, 0, 0, '0, '0, 0, ga, gb);
    idle(1);
    drive(0, 0, '0, '0, 0, 0, '0, '0, 1, ga, gb);
    sweep(-1, 50);
    drive(1, 0, 8'h20, '0, 0, 0, '0, '0, 0, ga, gb);
    idle(1);

    // Randomized traffic; requests held until the model says they were granted.
    pa = 0;  pb = 0;
    pwa = 0; pwb = 0; paa = '0; pab = '0; pda = '0; pdb = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pa) begin
        pa  = ($urandom_range(0, 3) != 0);
        pwa = 1'($urandom);
        paa = ($urandom_range(0, 7) == 0) ? 8'hFF : ADDR_W'($urandom_range(0, 7));
        pda = DATA_W'($urandom);
      end
      if (!pb) begin
        pb  = ($urandom_range(0, 3) != 0);
        pwb = 1'($urandom);
        pab = ($urandom_range(0, 7) == 0) ? 8'hFF : ADDR_W'($urandom_range(0, 7));
        pdb = DATA_W'($urandom);
      end
      drive(pa, pwa, paa, pda, pb, pwb, pab, pdb, 0, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    idle(2);

    // Reset while a read response is on the outputs.
    drive(1, 0, 8'h10, '0, 0, 0, '0, '0, 0, ga, gb);
    apply_reset();

    // Reset mid-sweep at clr_cnt = 100, then a full clean sweep.
    release_and_sweep(100);
    release_and_sweep(-1);

    // Contention straight after reset: A wins the first tie, then alternation.
    for (int k = 0; k < 4; k++) drive(1, 0, 8'h10, '0, 1, 0, 8'h11, '0, 0, ga, gb);
    for (int k = 0; k < 3; k++) drive(0, 0, '0, '0, 1, 1, ADDR_W'(k), DATA_W'(k + 7), 0, ga, gb);
    idle(3);

    check("q_a_drained", 32'(q_a.size()), 32'(0));
    check("q_b_drained", 32'(q_b.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
